// File: rtl/uart_tx_arbiter_pkg.sv
// uart_arb_pkg: shared types for the two-requester UART transmit arbiter
package uart_arb_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, START, DRAIN} state_e;
   typedef logic req_idx_t;
   localparam logic [1:0] GRANT_NONE = 2'b00;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker that favours the requester not served last
module rr_pick2
   import uart_arb_pkg::*;
(
   input  logic [1:0] valid_i,
   input  req_idx_t   last_served_i,
   output logic [1:0] grant_o
);
   always_comb grant_o = &valid_i ? (last_served_i ? 2'b01 : 2'b10) : valid_i;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX core between two byte streams with
// round-robin grants locked until a last byte or an idle timeout
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 1024
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] req0_data,
   input  logic                  req0_valid,
   input  logic                  req0_last,
   output logic                  req0_ready,
   input  logic [DATA_WIDTH-1:0] req1_data,
   input  logic                  req1_valid,
   input  logic                  req1_last,
   output logic                  req1_ready,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_start,
   input  logic                  tx_busy,
   output logic [1:0]            grant,
   output logic                  timeout_evt
);
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] IDLE_MAX = CW'(TIMEOUT - 1);
   state_e                state_q;
   logic [1:0]            grant_q;
   req_idx_t              last_served_q;
   logic [DATA_WIDTH-1:0] tx_data_q;
   logic                  tx_start_q;
   logic                  last_flag_q;
   logic [CW-1:0]         idle_q;
   logic [1:0]            win;
   req_idx_t              owner_idx;
   logic                  owner_valid;
   logic                  owner_last;
   logic [DATA_WIDTH-1:0] owner_data;
   logic                  in_load;
   logic                  xfer;
   logic                  expire;
   rr_pick2 u_pick (
      .valid_i       ({req1_valid, req0_valid}),
      .last_served_i (last_served_q),
      .grant_o       (win)
   );
   always_comb begin
      owner_idx   = grant_q[1];
      owner_valid = grant_q[1] ? req1_valid : req0_valid;
      owner_last  = grant_q[1] ? req1_last  : req0_last;
      owner_data  = grant_q[1] ? req1_data  : req0_data;
      in_load     = state_q == LOAD;
      xfer        = in_load && owner_valid && !tx_busy;
      expire      = in_load && !owner_valid && idle_q == IDLE_MAX;
   end
   assign req0_ready  = in_load && grant_q[0] && !tx_busy;
   assign req1_ready  = in_load && grant_q[1] && !tx_busy;
   assign tx_data     = tx_data_q;
   assign tx_start    = tx_start_q;
   assign grant       = grant_q;
   assign timeout_evt = expire;
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         grant_q       <= GRANT_NONE;
         last_served_q <= 1'b1;
         tx_data_q     <= '0;
         tx_start_q    <= 1'b0;
         last_flag_q   <= 1'b0;
         idle_q        <= '0;
      end else begin
         tx_start_q <= 1'b0;
         case (state_q)
            IDLE:
               if (|win) begin
                  grant_q <= win;
                  idle_q  <= '0;
                  state_q <= LOAD;
               end
            LOAD:
               if (xfer) begin
                  tx_data_q   <= owner_data;
                  last_flag_q <= owner_last;
                  idle_q      <= '0;
                  tx_start_q  <= 1'b1;
                  state_q     <= START;
               end else if (expire) begin
                  last_served_q <= owner_idx;
                  grant_q       <= GRANT_NONE;
                  state_q       <= IDLE;
               end else if (!owner_valid) begin
                  idle_q <= idle_q + CW'(1);
               end
            START: state_q <= DRAIN;
            DRAIN:
               if (!tx_busy) begin
                  if (last_flag_q) begin
                     last_served_q <= owner_idx;
                     grant_q       <= GRANT_NONE;
                     state_q       <= IDLE;
                  end else begin
                     idle_q  <= '0;
                     state_q <= LOAD;
                  end
               end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vectors and corner sequences for uart_tx_arbiter
module tb_uart_tx_arbiter;
   logic       clock, reset;
   logic [7:0] req0_data, req1_data, tx_data;
   logic       req0_valid, req0_last, req0_ready;
   logic       req1_valid, req1_last, req1_ready;
   logic       tx_start, tx_busy, timeout_evt;
   logic [1:0] grant;
   logic       force_busy;
   int         bcnt;
   logic [7:0] sent [$];
   int         checks = 0;
   int         failures = 0;

   typedef struct {
      logic       v0, v1;
      logic [7:0] d0, d1;
      logic [1:0] g;
      logic [7:0] d;
   } vec_t;
   vec_t       tbl [8];
   logic [7:0] lock_b [3];

   uart_tx_arbiter #(.DATA_WIDTH(8), .TIMEOUT(16)) dut (
      .clock(clock), .reset(reset),
      .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
      .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
      .grant(grant), .timeout_evt(timeout_evt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // UART core stand-in: busy for 10 cycles after each sampled start
   always @(posedge clock or negedge reset)
      if (!reset) bcnt <= 0;
      else if (tx_start) begin bcnt <= 10; sent.push_back(tx_data); end
      else if (bcnt != 0) bcnt <= bcnt - 1;
   assign tx_busy = (bcnt != 0) || force_busy;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_grant(input string name, input logic [1:0] g, input int lim);
      int n = 0;
      while (grant !== g && n < lim) begin step(); n++; end
      check(name, {30'd0, grant}, {30'd0, g});
   endtask

   initial begin
      int idx, loads, bad;
      logic x0, x1;
      tbl[0] = '{1'b1, 1'b1, 8'h30, 8'h50, 2'b01, 8'h30};
      tbl[1] = '{1'b1, 1'b1, 8'h31, 8'h51, 2'b10, 8'h51};
      tbl[2] = '{1'b1, 1'b1, 8'h32, 8'h52, 2'b01, 8'h32};
      tbl[3] = '{1'b0, 1'b1, 8'h33, 8'h53, 2'b10, 8'h53};
      tbl[4] = '{1'b0, 1'b1, 8'h34, 8'h54, 2'b10, 8'h54};
      tbl[5] = '{1'b1, 1'b0, 8'h35, 8'h55, 2'b01, 8'h35};
      tbl[6] = '{1'b1, 1'b1, 8'h36, 8'h56, 2'b10, 8'h56};
      tbl[7] = '{1'b1, 1'b1, 8'h37, 8'h57, 2'b01, 8'h37};
      lock_b[0] = 8'h6F; lock_b[1] = 8'h6B; lock_b[2] = 8'h0A;
      reset = 1'b0; force_busy = 1'b0;
      req0_data = 8'h00; req0_valid = 1'b0; req0_last = 1'b0;
      req1_data = 8'h00; req1_valid = 1'b0; req1_last = 1'b0;
      repeat (3) step();
      check("rst_grant", {30'd0, grant}, 32'h0);
      check("rst_tx_data", {24'd0, tx_data}, 32'h0);
      check("rst_outs", {28'd0, tx_start, req0_ready, req1_ready, timeout_evt}, 32'h0);
      reset = 1'b1;
      step();

      // single request
      sent.delete();
      req0_valid = 1'b1; req0_data = 8'h41; req0_last = 1'b1;
      step();
      check("single_grant", {30'd0, grant}, 32'h1);
      check("single_ready", {31'd0, req0_ready}, 32'h1);
      check("single_no_early_start", {31'd0, tx_start}, 32'h0);
      step();
      req0_valid = 1'b0;
      check("single_start", {31'd0, tx_start}, 32'h1);
      check("single_data", {24'd0, tx_data}, 32'h41);
      step();
      check("single_start_once", {31'd0, tx_start}, 32'h0);
      wait_grant("single_release", 2'b00, 40);
      check("single_start_count", sent.size(), 1);

      // arbitration table from a fresh reset
      reset = 1'b0; step(); reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         req0_valid = tbl[i].v0; req1_valid = tbl[i].v1;
         req0_data = tbl[i].d0; req1_data = tbl[i].d1;
         req0_last = 1'b1; req1_last = 1'b1;
         step();
         check($sformatf("tbl%0d_grant", i), {30'd0, grant}, {30'd0, tbl[i].g});
         check($sformatf("tbl%0d_ready", i), {30'd0, req1_ready, req0_ready}, {30'd0, tbl[i].g});
         step();
         req0_valid = 1'b0; req1_valid = 1'b0;
         check($sformatf("tbl%0d_data", i), {24'd0, tx_data}, {24'd0, tbl[i].d});
         wait_grant($sformatf("tbl%0d_release", i), 2'b00, 40);
      end

      // lock: req1 message completes while req0 waits
      sent.delete();
      bad = 0; idx = 0;
      req0_valid = 1'b1; req0_data = 8'h99; req0_last = 1'b1;
      req1_valid = 1'b1; req1_data = lock_b[0]; req1_last = 1'b0;
      step();
      check("lock_grant", {30'd0, grant}, 32'h2);
      for (int c = 0; c < 300 && sent.size() < 4; c++) begin
         if (grant == 2'b10 && req0_ready) bad++;
         x0 = req0_valid && req0_ready;
         x1 = req1_valid && req1_ready;
         step();
         if (x1) begin
            idx++;
            if (idx < 3) begin req1_data = lock_b[idx]; req1_last = (idx == 2); end
            else req1_valid = 1'b0;
         end
         if (x0) req0_valid = 1'b0;
      end
      check("lock_count", sent.size(), 4);
      for (int i = 0; i < 3; i++)
         check($sformatf("lock_byte%0d", i), {24'd0, (i < sent.size()) ? sent[i] : 8'hxx}, {24'd0, lock_b[i]});
      check("lock_req0_byte", {24'd0, (sent.size() > 3) ? sent[3] : 8'hxx}, 32'h99);
      check("lock_req0_ready_low", bad, 0);
      wait_grant("lock_release", 2'b00, 40);

      // timeout after a non-last byte
      req0_valid = 1'b1; req0_data = 8'h11; req0_last = 1'b0;
      step();
      check("to_grant", {30'd0, grant}, 32'h1);
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_data = 8'h22; req1_last = 1'b1;
      for (int n = 0; n < 40 && !req0_ready; n++) step();
      check("to_reload", {31'd0, req0_ready}, 32'h1);
      loads = 1;
      while (!timeout_evt && loads < 40) begin step(); loads++; end
      check("to_load_cycles", loads, 16);
      check("to_evt", {31'd0, timeout_evt}, 32'h1);
      step();
      check("to_evt_pulse", {31'd0, timeout_evt}, 32'h0);
      check("to_grant_none", {30'd0, grant}, 32'h0);
      step();
      check("to_regrant", {30'd0, grant}, 32'h2);
      step();
      req1_valid = 1'b0;
      check("to_req1_data", {24'd0, tx_data}, 32'h22);
      wait_grant("to_release", 2'b00, 40);

      // backpressure does not count toward timeout
      force_busy = 1'b1;
      req0_valid = 1'b1; req0_data = 8'h55; req0_last = 1'b1;
      step();
      check("bp_grant", {30'd0, grant}, 32'h1);
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         if (req0_ready || tx_start || timeout_evt) bad++;
         step();
      end
      check("bp_quiet", bad, 0);
      force_busy = 1'b0;
      #1;
      check("bp_ready", {31'd0, req0_ready}, 32'h1);
      step();
      req0_valid = 1'b0;
      check("bp_start", {31'd0, tx_start}, 32'h1);
      check("bp_data", {24'd0, tx_data}, 32'h55);
      wait_grant("bp_release", 2'b00, 40);

      // asynchronous reset while draining
      req0_valid = 1'b1; req0_data = 8'h66; req0_last = 1'b0;
      step();
      step();
      req0_valid = 1'b0;
      step();
      step();
      check("rd_in_drain", {30'd0, grant}, 32'h1);
      req0_valid = 1'b1; req0_data = 8'h77; req0_last = 1'b1;
      req1_valid = 1'b1; req1_data = 8'h88; req1_last = 1'b1;
      #2 reset = 1'b0;
      #1;
      check("rd_grant", {30'd0, grant}, 32'h0);
      check("rd_tx_data", {24'd0, tx_data}, 32'h0);
      check("rd_outs", {28'd0, tx_start, req0_ready, req1_ready, timeout_evt}, 32'h0);
      @(posedge clock);
      #1 reset = 1'b1;
      step();
      check("rd_first_grant", {30'd0, grant}, 32'h1);
      step();
      req0_valid = 1'b0;
      check("rd_first_data", {24'd0, tx_data}, 32'h77);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
